// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the SRAM arbiter: state encodings, port select, bus widths.
package mem_arbiter_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 18;
  localparam int unsigned MEM_ARB_DATA_W = 16;
  localparam int unsigned MEM_ARB_CNT_W  = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRd      = 3'd1,
    StWrSetup = 3'd2,
    StWrPulse = 3'd3,
    StWrHold  = 3'd4,
    StDone    = 3'd5
  } state_e;

  typedef enum logic {
    PortIf  = 1'b0,
    PortMem = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter timing the SRAM read and write-pulse phases.
module mem_arb_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the final cycle of the loaded phase.
  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the external SRAM between instruction fetch and data memory ports.
// Optional one-entry fetch buffer enabled by defining MEM_ARB_IFBUF_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W    = MEM_ARB_DATA_W,
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_doe,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  state_e                    state_q, state_d;
  port_e                     port_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [DATA_W-1:0]         wdata_q;
  logic [DATA_W-1:0]         if_rdata_q, mem_rdata_q;
  logic                      timer_start, timer_done;
  logic [MEM_ARB_CNT_W-1:0]  timer_load;
  logic                      buf_hit;
  logic [DATA_W-1:0]         buf_hit_data;
  logic                      rd_capture;

  mem_arb_timer #(
    .CNT_W(MEM_ARB_CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (timer_start),
    .load_val(timer_load),
    .done    (timer_done)
  );

  assign rd_capture = (state_q == StRd) && timer_done;

`ifdef MEM_ARB_IFBUF_EN
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_tag_q;
  logic [DATA_W-1:0] buf_data_q;

  assign buf_hit      = buf_valid_q && (buf_tag_q == if_addr);
  assign buf_hit_data = buf_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else if (rd_capture && (port_q == PortIf)) begin
      buf_valid_q <= 1'b1;
      buf_tag_q   <= addr_q;
      buf_data_q  <= sram_din;
    end else if ((state_q == StWrSetup) && (addr_q == buf_tag_q)) begin
      buf_valid_q <= 1'b0;
    end
  end
`else
  assign buf_hit      = 1'b0;
  assign buf_hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_start = 1'b0;
    timer_load  = '0;
    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          if (mem_we) begin
            state_d = StWrSetup;
          end else begin
            state_d     = StRd;
            timer_start = 1'b1;
            timer_load  = MEM_ARB_CNT_W'(RD_CYCLES);
          end
        end else if (if_req) begin
          if (buf_hit) begin
            state_d = StDone;
          end else begin
            state_d     = StRd;
            timer_start = 1'b1;
            timer_load  = MEM_ARB_CNT_W'(RD_CYCLES);
          end
        end
      end
      StRd: begin
        if (timer_done) state_d = StDone;
      end
      StWrSetup: begin
        state_d     = StWrPulse;
        timer_start = 1'b1;
        timer_load  = MEM_ARB_CNT_W'(WR_CYCLES);
      end
      StWrPulse: begin
        if (timer_done) state_d = StWrHold;
      end
      StWrHold: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_doe  = 1'b0;
    unique case (state_q)
      StRd: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
      end
      StWrSetup, StWrHold: begin
        sram_ce_n = 1'b0;
        sram_doe  = 1'b1;
      end
      StWrPulse: begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        sram_doe  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      port_q      <= PortIf;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (state_q == StIdle) begin
        if (mem_req) begin
          port_q  <= PortMem;
          addr_q  <= mem_addr;
          wdata_q <= mem_wdata;
        end else if (if_req) begin
          port_q <= PortIf;
          addr_q <= if_addr;
          if (buf_hit) if_rdata_q <= buf_hit_data;
        end
      end
      if (rd_capture) begin
        if (port_q == PortMem) begin
          mem_rdata_q <= sram_din;
        end else begin
          if_rdata_q <= sram_din;
        end
      end
    end
  end

  assign sram_addr = addr_q;
  assign sram_dout = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ack    = (state_q == StDone) && (port_q == PortIf);
  assign mem_ack   = (state_q == StDone) && (port_q == PortMem);
  assign if_stall  = if_req & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus random two-port traffic
// against a behavioural SRAM and reference memory. Covers MEM_ARB_IFBUF_EN when defined.
module tb_mem_arbiter;

  localparam int unsigned AW  = 18;
  localparam int unsigned DW  = 16;
  localparam int unsigned RDC = 2;
  localparam int unsigned WRC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          if_stall;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          mem_stall;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout;
  logic          sram_doe;
  logic [DW-1:0] sram_din = '0;
  logic          sram_ce_n, sram_oe_n, sram_we_n;

  always #10 clk = ~clk;

  mem_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RD_CYCLES(RDC),
    .WR_CYCLES(WRC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .if_stall (if_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .mem_stall(mem_stall),
    .sram_addr(sram_addr),
    .sram_dout(sram_dout),
    .sram_doe (sram_doe),
    .sram_din (sram_din),
    .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Chip contents and the expected contents kept separately.
  logic [DW-1:0] sram_m [int];
  logic [DW-1:0] ref_m  [int];

  function automatic logic [DW-1:0] init_val(input int a);
    logic [DW-1:0] v;
    v = (16'(a) * 16'h9E37) ^ 16'h5A5A;
    return v;
  endfunction

  function automatic logic [DW-1:0] sram_rd(input int a);
    return sram_m.exists(a) ? sram_m[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_m.exists(a) ? ref_m[a] : init_val(a);
  endfunction

  // SRAM latches on the rising edge of we_n, provided data is still driven.
  logic prev_we_n = 1'b1;
  always @(negedge clk) begin
    if (!prev_we_n && sram_we_n && !sram_ce_n && sram_doe)
      sram_m[int'(sram_addr)] = sram_dout;
    prev_we_n = sram_we_n;
    sram_din = (!sram_ce_n && !sram_oe_n) ? sram_rd(int'(sram_addr)) : 16'($urandom);
  end

  typedef struct {
    bit            wr;
    logic [DW-1:0] data;
    int            at;
  } exp_t;

  exp_t if_q[$];
  exp_t mem_q[$];

  int oe_run = 0, we_run = 0, doe_run = 0, ce_low = 0;
  bit dirty = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    chk("single_ack", {31'b0, if_ack & mem_ack}, 32'd0);
    chk("if_stall", {31'b0, if_stall}, {31'b0, if_req & ~if_ack});
    chk("mem_stall", {31'b0, mem_stall}, {31'b0, mem_req & ~mem_ack});

    if (!rst) dirty = 1'b1;
    if (!sram_ce_n) ce_low++;
    if (!sram_oe_n) oe_run++;
    else if (oe_run != 0) begin
      if (!dirty) chk("oe_n_low_cycles", oe_run, RDC);
      oe_run = 0;
    end
    if (!sram_we_n) we_run++;
    else if (we_run != 0) begin
      if (!dirty) chk("we_n_low_cycles", we_run, WRC);
      we_run = 0;
    end
    if (sram_doe) doe_run++;
    else if (doe_run != 0) begin
      if (!dirty) chk("doe_high_cycles", doe_run, WRC + 2);
      doe_run = 0;
    end
    if (rst && oe_run == 0 && we_run == 0 && doe_run == 0) dirty = 1'b0;

    if (if_ack) begin
      chk("if_ack_pending", {31'b0, if_q.size() > 0}, 32'd1);
      if (if_q.size() > 0) begin
        e = if_q.pop_front();
        chk("if_rdata", {16'b0, if_rdata}, {16'b0, e.data});
        if (e.at >= 0) chk("if_ack_cycle", cyc, e.at);
      end
    end
    if (mem_ack) begin
      chk("mem_ack_pending", {31'b0, mem_q.size() > 0}, 32'd1);
      if (mem_q.size() > 0) begin
        e = mem_q.pop_front();
        if (!e.wr) chk("mem_rdata", {16'b0, mem_rdata}, {16'b0, e.data});
        if (e.at >= 0) chk("mem_ack_cycle", cyc, e.at);
      end
    end
  end

  // Called just after a posedge; lat < 0 skips the latency check.
  task automatic do_if(input logic [AW-1:0] a, input int lat);
    exp_t e;
    bit   seen;
    e.wr   = 1'b0;
    e.data = ref_rd(int'(a));
    e.at   = (lat < 0) ? -1 : cyc + lat;
    if_q.push_back(e);
    if_addr = a;
    if_req  = 1'b1;
    seen    = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = if_ack;
    end
    chk("if_ack_timeout", {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic do_mem(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int lat, input bit hold);
    exp_t e;
    bit   seen;
    e.wr   = we;
    e.data = ref_rd(int'(a));
    e.at   = (lat < 0) ? -1 : cyc + lat;
    if (we) ref_m[int'(a)] = d;
    mem_q.push_back(e);
    mem_we    = we;
    mem_addr  = a;
    mem_wdata = d;
    mem_req   = 1'b1;
    seen      = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = mem_ack;
    end
    chk("mem_ack_timeout", {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) mem_req = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] orig;
    int            c0;

    sram_m[32'h10] = 16'h6A05;
    ref_m[32'h10]  = 16'h6A05;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
    chk("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
    chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("rst_doe", {31'b0, sram_doe}, 32'd0);
    chk("rst_addr", {14'b0, sram_addr}, 32'd0);
    chk("rst_dout", {16'b0, sram_dout}, 32'd0);
    chk("rst_if_rdata", {16'b0, if_rdata}, 32'd0);
    chk("rst_mem_rdata", {16'b0, mem_rdata}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_if(18'h00010, RDC + 1);
    do_mem(1'b1, 18'h3FF00, 16'hBEEF, WRC + 3, 1'b0);
    do_mem(1'b0, 18'h3FF00, 16'h0000, RDC + 1, 1'b0);

    fork
      do_if(18'h00030, 2 * RDC + 3);
      do_mem(1'b0, 18'h00031, 16'h0000, RDC + 1, 1'b0);
    join

    do_mem(1'b0, 18'h3FF00, 16'h0000, RDC + 1, 1'b1);
    do_mem(1'b0, 18'h00040, 16'h0000, RDC + 1, 1'b1);
    do_mem(1'b0, 18'h00041, 16'h0000, RDC + 1, 1'b0);

    // Abort a write in its WE_n pulse.
    orig      = sram_rd(32'h50);
    mem_we    = 1'b1;
    mem_addr  = 18'h00050;
    mem_wdata = ~orig;
    mem_req   = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b1;
    mem_req = 1'b0;
    @(negedge clk);
    chk("abort_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("abort_doe", {31'b0, sram_doe}, 32'd0);
    chk("abort_ce_n", {31'b0, sram_ce_n}, 32'd1);
    chk("abort_mem_rdata", {16'b0, mem_rdata}, 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_sram_unchanged", {16'b0, sram_rd(32'h50)}, {16'b0, orig});
    @(posedge clk);
    #1;

    do_if(18'h00020, RDC + 1);
    c0 = ce_low;
`ifdef MEM_ARB_IFBUF_EN
    do_if(18'h00020, 1);
    chk("ifbuf_hit_no_ce", ce_low - c0, 0);
`else
    do_if(18'h00020, RDC + 1);
    chk("refetch_ce_cycles", ce_low - c0, RDC);
`endif
    do_mem(1'b1, 18'h00020, 16'h1234, WRC + 3, 1'b0);
    c0 = ce_low;
    do_if(18'h00020, RDC + 1);
    chk("refetch_after_write_ce", ce_low - c0, RDC);

    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          do_if(18'h00100 + 18'($urandom_range(0, 7)), -1);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          do_mem(1'($urandom_range(0, 1)), 18'h00200 + 18'($urandom_range(0, 15)),
                 16'($urandom), -1, 1'b0);
        end
      end
    join

    for (int n = 0; n < 500 && (if_q.size() != 0 || mem_q.size() != 0); n++) @(negedge clk);
    chk("if_queue_drained", if_q.size(), 0);
    chk("mem_queue_drained", mem_q.size(), 0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
